data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_map_pkg.sv | 34 +++
 rtl/console_fifo.sv | 65 ++++++
 rtl/data_mem_responder.sv | 88 ++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, default sizes and address decode shared by the data memory
// responder and its console FIFO.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] CONSOLE_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] STATUS_ADDR  = 32'hFFFF_0008;

  localparam int DEF_RAM_WORDS  = 1024;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_CYCLE,
    REGION_CONSOLE,
    REGION_STATUS,
    REGION_NONE
  } region_e;

  // Word-granular decode: the two byte-offset bits never take part.
  function automatic region_e decode_addr(input logic [31:0] a, input int ram_words);
    logic [31:0] off;
    logic [31:0] word_off;
    off      = a - RAM_BASE;
    word_off = {2'b00, off[31:2]};
    if (word_off < $unsigned(ram_words))       return REGION_RAM;
    else if (a[31:2] == CYCLE_ADDR[31:2])      return REGION_CYCLE;
    else if (a[31:2] == CONSOLE_ADDR[31:2])    return REGION_CONSOLE;
    else if (a[31:2] == STATUS_ADDR[31:2])     return REGION_STATUS;
    else                                       return REGION_NONE;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console sink; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module console_fifo
  import mem_map_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the gated head keeps tx_data at zero when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory stage responder: word RAM, free-running cycle counter, and a
// console byte FIFO with sticky overflow, all behind one address map.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = DEF_RAM_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic [31:0] addr,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q [RAM_WORDS];
  logic              ram_we;

  logic [31:0]       cycle_q, cycle_d;
  logic              ovf_q, ovf_d;

  logic              push_req, pop_req;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  assign region   = decode_addr(addr, RAM_WORDS);
  assign ram_idx  = addr[RAM_AW+1:2];
  assign ram_we   = mem_en & ~reset & (region == REGION_RAM);
  assign push_req = mem_en & ~reset & (region == REGION_CONSOLE);
  assign pop_req  = tx_valid & tx_ready & ~reset;

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (mem_data[7:0]),
    .pop       (pop_req),
    .data      (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_valid = ~fifo_empty;

  // Overflow is only raised when a byte is actually lost, not when a pop
  // makes room for it in the same cycle.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q;
    if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
    if (mem_en && (region == REGION_STATUS) && mem_data[31]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_data;
  end

  always_comb begin
    mem_out = 32'h0;
    case (region)
      REGION_RAM:    mem_out = ram_q[ram_idx];
      REGION_CYCLE:  mem_out = cycle_q;
      REGION_STATUS: mem_out = {ovf_q, 27'b0, 4'(fifo_count)};
      default:       mem_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a table of RAM/decode vectors plus
// hand-written sequences for the counter, console FIFO and reset behaviour.
module tb_data_mem_responder;

  localparam logic [31:0] A_CYCLE   = 32'hFFFF_0000;
  localparam logic [31:0] A_CONSOLE = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic [31:0] addr;
  logic [31:0] mem_data;
  logic [31:0] mem_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        en;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .mem_en   (mem_en),
    .addr     (addr),
    .mem_data (mem_data),
    .mem_out  (mem_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] a, input logic [31:0] wd,
                     input logic c, input logic [31:0] exp);
    vec_t v;
    v.en = en; v.a = a; v.wd = wd; v.chk = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    mem_en   = 1'b1;
    addr     = A_CONSOLE;
    mem_data = {24'h0, b};
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    @(negedge clk);
    mem_en = 1'b0;
    addr   = A_STATUS;
    #1;
    chk(name, mem_out, exp);
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    n_vec    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    mem_en   = 1'b0;
    addr     = 32'h0;
    mem_data = 32'h0;
    tx_ready = 1'b0;

    add(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    add(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0);
    add(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add(1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 32'h0);
    add(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111);
    add(1'b1, 32'h8000_0010, 32'h0BAD_BAD0, 1'b1, 32'h0);
    add(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add(1'b1, A_CYCLE,       32'h0,         1'b0, 32'h0);
    add(1'b0, A_CONSOLE,     32'h0,         1'b1, 32'h0);
    add(1'b0, A_STATUS,      32'h0,         1'b1, 32'h0);
    add(1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0);
    add(1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'h0);
    add(1'b0, 32'h0000_0016, 32'h0,         1'b1, 32'h1234_5678);
    add(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b0, 32'h0);
    add(1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hA5A5_A5A5);
    add(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111);

    // Reset state
    repeat (2) @(negedge clk);
    addr = A_STATUS;
    #1;
    chk("rst_status", mem_out, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    reset = 1'b0;

    // Cycle counter: five cycles after release, then wrap
    repeat (5) @(posedge clk);
    @(negedge clk);
    addr = A_CYCLE;
    #1;
    chk("cycle_after5", mem_out, 32'd5);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    chk("cycle_forced", mem_out, 32'hFFFF_FFFF);
    release dut.cycle_q;
    @(negedge clk);
    #1;
    chk("cycle_wrap", mem_out, 32'h0);
    @(negedge clk);
    #1;
    chk("cycle_after_wrap", mem_out, 32'h1);

    // RAM and decode table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mem_en   = vecs[i].en;
      addr     = vecs[i].a;
      mem_data = vecs[i].wd;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d", i), mem_out, vecs[i].exp);
    end

    // Two bytes queued with sink stalled, then drained
    push_byte(8'h41);
    #1;
    chk("no_bypass", {31'h0, tx_valid}, 32'h0);
    push_byte(8'h42);
    read_status("status_two", 32'h0000_0002);
    chk("head_41", {24'h0, tx_data}, 32'h41);
    chk("valid_two", {31'h0, tx_valid}, 32'h1);
    @(negedge clk);
    #1;
    chk("head_stable", {24'h0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    #1;
    chk("emit_41", {24'h0, tx_data}, 32'h41);
    @(negedge clk);
    #1;
    chk("emit_42", {24'h0, tx_data}, 32'h42);
    @(negedge clk);
    #1;
    chk("valid_drop", {31'h0, tx_valid}, 32'h0);
    read_status("empty_pop_ignored", 32'h0);
    tx_ready = 1'b0;

    // Overflow on the ninth push, then clear
    for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i));
    read_status("status_ovf", 32'h8000_0008);
    chk("head_60", {24'h0, tx_data}, 32'h60);
    @(negedge clk);
    mem_en = 1'b1; addr = A_STATUS; mem_data = 32'h7FFF_FFFF;
    read_status("status_no_clear", 32'h8000_0008);
    @(negedge clk);
    mem_en = 1'b1; addr = A_STATUS; mem_data = 32'h8000_0000;
    read_status("status_cleared", 32'h0000_0008);

    // Full FIFO with simultaneous push and pop
    @(negedge clk);
    mem_en = 1'b1; addr = A_CONSOLE; mem_data = 32'h0000_0055; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    mem_en   = 1'b0;
    addr     = A_STATUS;
    #1;
    chk("full_push_pop", mem_out, 32'h0000_0008);
    for (int k = 0; k < 7; k++) drain_exp[k] = 8'h61 + 8'(k);
    drain_exp[7] = 8'h55;
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, drain_exp[k]});
      @(negedge clk);
      #1;
    end
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Reset with bytes queued; RAM untouched, writes ignored during reset
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    read_status("status_three", 32'h0000_0003);
    @(negedge clk);
    reset = 1'b1; mem_en = 1'b1; addr = A_CONSOLE; mem_data = 32'h0000_00A4; tx_ready = 1'b1;
    @(negedge clk);
    mem_en = 1'b1; addr = 32'h0000_0010; mem_data = 32'h0; tx_ready = 1'b0;
    #1;
    chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst2_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst2_ram", mem_out, 32'hDEAD_BEEF);
    addr = A_STATUS;
    #1;
    chk("rst2_status", mem_out, 32'h0);
    addr = 32'h0000_0010;
    @(negedge clk);
    reset  = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("rst2_ram_kept", mem_out, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    chk("rst2_still_empty", {31'h0, tx_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
